toggle_counter: RTL

Parametrised successor to the single-bit T flip-flop: a WIDTH-bit counter advanced by a toggle-enable input `T`, with up/down direction, synchronous load, programmable modulus, optional saturation, a terminal-count flag and a divide-by-modulus toggle output. It serves as the shared counting/dividing primitive for the project's timing and sequencing blocks, wherever the single T_FF was previously chained.

---
 rtl/toggle_counter_if.sv | 22 ++
 rtl/toggle_counter.sv | 63 ++++++
 2 files changed

// File: rtl/toggle_counter_if.sv
// Control and observation bundle for toggle_counter: count/load strobes in, count and flags out.
interface toggle_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             T;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             toggle_out;

    modport master (
        output T, up_dn, load, load_val,
        input  Q, tc, toggle_out
    );

    modport slave (
        input  T, up_dn, load, load_val,
        output Q, tc, toggle_out
    );
endinterface

// File: rtl/toggle_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with load, optional saturation, terminal count and divide toggle.
// Q/toggle_out register one cycle after the sampling edge; tc is combinational; no backpressure.
module toggle_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    toggle_counter_if.slave  cnt
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             tog_r;
    logic             tog_nxt;
    logic             at_max;
    logic             at_min;

    assign at_max = (q_r == MAX_Q);
    assign at_min = (q_r == '0);

    always_comb begin
        q_nxt   = q_r;
        tog_nxt = tog_r;
        if (cnt.load) begin
            q_nxt = (cnt.load_val > MAX_Q) ? MAX_Q : cnt.load_val;
        end else if (cnt.T) begin
            if (cnt.up_dn) begin
                if (!at_max) begin
                    q_nxt = q_r + WIDTH'(1);
                end else if (!SATURATE) begin
                    q_nxt   = '0;
                    tog_nxt = ~tog_r;
                end
            end else begin
                if (!at_min) begin
                    q_nxt = q_r - WIDTH'(1);
                end else if (!SATURATE) begin
                    q_nxt   = MAX_Q;
                    tog_nxt = ~tog_r;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r   <= '0;
            tog_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            tog_r <= tog_nxt;
        end
    end

    // tc flags the limit about to be crossed (or held against), gated off during reset and load
    assign cnt.tc         = !reset && cnt.T && !cnt.load &&
                            ((cnt.up_dn && at_max) || (!cnt.up_dn && at_min));
    assign cnt.Q          = q_r;
    assign cnt.toggle_out = tog_r;
endmodule
